// File: rtl/rv_structs.sv
// Shared rename/ROB-side types: CDB lane width and the per-lane bus payload.
package rv_structs;

  localparam int NUM_CDB_LANES = 5;
  localparam int ROB_IDX_W     = 5;
  localparam int DATA_W        = 32;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] dest_rob;
    logic [DATA_W-1:0]    value;
  } data_bus;

endpackage

// File: rtl/rr_priority_select.sv
// Rotating first-N selector: scans valid_i from ptr_i upward (wrapping) and
// hands the first NUM_LANES hits to lanes 0..NUM_LANES-1 in scan order.
module rr_priority_select #(
  parameter int NUM_REQ   = 8,
  parameter int NUM_LANES = 5,
  parameter int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]              valid_i,
  input  logic [PTR_W-1:0]                ptr_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic [NUM_LANES-1:0]            lane_vld_o,
  output logic [NUM_LANES-1:0][PTR_W-1:0] lane_idx_o,
  output logic [PTR_W-1:0]                last_idx_o
);

  localparam int CW = $clog2(NUM_LANES + 1);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic [CW-1:0]    cnt;

  // Walk requesters in rotated order, filling lanes until they run out.
  always_comb begin
    grant_o    = '0;
    lane_vld_o = '0;
    lane_idx_o = '0;
    last_idx_o = '0;
    cnt        = '0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (valid_i[idx] && (cnt < CW'(NUM_LANES))) begin
        grant_o[idx] = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) begin
          if (cnt == CW'(l)) begin
            lane_vld_o[l] = 1'b1;
            lane_idx_o[l] = idx;
          end
        end
        last_idx_o = idx;
        cnt        = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_LANES of NUM_REQ functional-unit
// results per cycle in round-robin order and registers them onto the CDB.
// Optional CDB_ARB_STATS_EN enables saturating stall/grant counters;
// without it both counter outputs are tied to zero.
module cdb_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int NUM_LANES = rv_structs::NUM_CDB_LANES,
  parameter int ROB_IDX_W = rv_structs::ROB_IDX_W,
  parameter int DATA_W    = rv_structs::DATA_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]   req_rob,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_value,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                flush,
  output rv_structs::data_bus [NUM_LANES-1:0] bus,
  output logic [31:0]                         stall_count,
  output logic [31:0]                         grant_count
);
  import rv_structs::data_bus;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_LANES-1:0]            lane_vld;
  logic [NUM_LANES-1:0][PTR_W-1:0] lane_idx;
  logic [PTR_W-1:0]                last_idx;
  data_bus [NUM_LANES-1:0]         bus_q, bus_d;

  rr_priority_select #(
    .NUM_REQ   (NUM_REQ),
    .NUM_LANES (NUM_LANES),
    .PTR_W     (PTR_W)
  ) u_sel (
    .valid_i    (req_valid),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .lane_vld_o (lane_vld),
    .lane_idx_o (lane_idx),
    .last_idx_o (last_idx)
  );

  // Grants are suppressed during reset and flush; depends only on inputs and rr_ptr.
  assign req_ready = (rst && !flush) ? grant : '0;
  assign bus       = bus_q;

  // Next CDB contents: lane k carries the k-th granted requester, others all-zero.
  always_comb begin
    bus_d = '0;
    if (!flush) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_vld[l]) begin
          bus_d[l].valid    = 1'b1;
          bus_d[l].dest_rob = req_rob[lane_idx[l]];
          bus_d[l].value    = req_value[lane_idx[l]];
        end
      end
    end
  end

  // Pointer moves just past the last winner; holds when idle, clears on flush.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (|grant) begin
      rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
    end
  end

  // Arbitration state and registered CDB lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      bus_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      bus_q    <= bus_d;
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stall_q, stall_d, grant_q, grant_d;
  logic [32:0] grant_sum;
  logic        stall_ev;

  assign stall_ev  = |(req_valid & ~req_ready);
  assign grant_sum = {1'b0, grant_q} + 33'($countones(req_valid & req_ready));

  // Saturating counter updates; both freeze at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (stall_ev && (stall_q != '1)) stall_d = stall_q + 32'd1;
    grant_d = grant_sum[32] ? '1 : grant_sum[31:0];
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      grant_q <= '0;
    end else begin
      stall_q <= stall_d;
      grant_q <= grant_d;
    end
  end

  assign stall_count = stall_q;
  assign grant_count = grant_q;
`else
  assign stall_count = '0;
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, rotation, flush, sparse requests,
// fairness, statistics and mid-transfer reset.
module tb_cdb_arbiter;
  import rv_structs::data_bus;

  localparam int NR = 8;
  localparam int NL = 5;
  localparam int RW = 5;
  localparam int DW = 32;
`ifdef CDB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0][RW-1:0]    req_rob;
  logic [NR-1:0][DW-1:0]    req_value;
  logic [NR-1:0]            req_ready;
  logic                     flush;
  data_bus [NL-1:0]         bus;
  logic [31:0]              stall_count, grant_count;

  int n_assert = 0;
  int n_fail   = 0;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_LANES(NL), .ROB_IDX_W(RW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rob     (req_rob),
    .req_value   (req_value),
    .req_ready   (req_ready),
    .flush       (flush),
    .bus         (bus),
    .stall_count (stall_count),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all();
    req_valid = '1;
    for (int i = 0; i < NR; i++) begin
      req_rob[i]   = RW'(i + 10);
      req_value[i] = 32'hA000_0000 + 32'(i);
    end
  endtask

  task automatic chk_ready(input string tag, input logic [NR-1:0] exp);
    n_assert++;
    assert (req_ready === exp) else begin
      n_fail++;
      $error("FAIL %s: req_ready=%h expected %h", tag, req_ready, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int l, input logic v,
                          input logic [RW-1:0] r, input logic [DW-1:0] d);
    data_bus e;
    e.valid    = v;
    e.dest_rob = r;
    e.value    = d;
    n_assert++;
    assert (bus[l] === e) else begin
      n_fail++;
      $error("FAIL %s lane%0d: got v=%b rob=%0d val=%h expected v=%b rob=%0d val=%h",
             tag, l, bus[l].valid, bus[l].dest_rob, bus[l].value, v, r, d);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int l = 0; l < NL; l++) chk_lane(tag, l, 1'b0, '0, '0);
  endtask

  task automatic chk_cnt(input string tag, input int s, input int g);
    logic [31:0] es, eg;
    es = STATS ? 32'(s) : 32'd0;
    eg = STATS ? 32'(g) : 32'd0;
    n_assert++;
    assert (stall_count === es) else begin
      n_fail++;
      $error("FAIL %s stall_count: got %0d expected %0d", tag, stall_count, es);
    end
    n_assert++;
    assert (grant_count === eg) else begin
      n_fail++;
      $error("FAIL %s grant_count: got %0d expected %0d", tag, grant_count, eg);
    end
  endtask

  initial begin
    int ord[5];
    rst   = 1'b0;
    flush = 1'b0;
    set_all();

    // Reset with every requester asking: nothing granted, bus and counters clear.
    #12;
    chk_ready("rst_ready", '0);
    chk_idle("rst_bus");
    chk_cnt("rst_cnt", 0, 0);

    // Release; first grant goes to requesters 0-4.
    @(negedge clk) rst = 1'b1;
    #1;
    chk_ready("first_grant", 8'h1F);
    tick();
    for (int k = 0; k < NL; k++)
      chk_lane("rot0_bus", k, 1'b1, RW'(k + 10), 32'hA000_0000 + 32'(k));
    chk_ready("rot1_ready", 8'hE3);
    tick();
    ord = '{5, 6, 7, 0, 1};
    for (int k = 0; k < NL; k++)
      chk_lane("rot1_bus", k, 1'b1, RW'(ord[k] + 10), 32'hA000_0000 + 32'(ord[k]));

    // Flush with six valid requesters.
    flush     = 1'b1;
    req_valid = 8'h3F;
    #1;
    chk_ready("flush_ready", '0);
    tick();
    flush     = 1'b0;
    req_valid = '0;
    chk_idle("flush_bus");
    #1;
    chk_ready("idle_ready", '0);
    tick();
    chk_idle("idle_bus");

    // Sparse: requesters 1, 4, 6 from rr_ptr=0.
    req_valid    = 8'b0101_0010;
    req_rob[1]   = 5'd3;  req_value[1] = 32'h10;
    req_rob[4]   = 5'd7;  req_value[4] = 32'h20;
    req_rob[6]   = 5'd9;  req_value[6] = 32'h30;
    #1;
    chk_ready("sparse_ready", 8'h52);
    tick();
    chk_lane("sparse_bus", 0, 1'b1, 5'd3, 32'h10);
    chk_lane("sparse_bus", 1, 1'b1, 5'd7, 32'h20);
    chk_lane("sparse_bus", 2, 1'b1, 5'd9, 32'h30);
    chk_lane("sparse_bus", 3, 1'b0, '0, '0);
    chk_lane("sparse_bus", 4, 1'b0, '0, '0);

    // Fairness: pointer returns to 0, then requester 7 must win within 2 cycles.
    req_valid = 8'h80;
    #1;
    chk_ready("solo7_ready", 8'h80);
    tick();
    set_all();
    #1;
    chk_ready("fair0_ready", 8'h1F);
    tick();
    chk_ready("fair1_ready", 8'hE3);
    n_assert++;
    assert (req_ready[7] === 1'b1) else begin
      n_fail++;
      $error("FAIL fair7: req_ready[7]=%b expected 1", req_ready[7]);
    end
    tick();

    // Statistics: flush pointer, 8 valid for one cycle, then 5-7 drain.
    flush     = 1'b1;
    req_valid = '0;
    tick();
    flush = 1'b0;
    set_all();
    #1;
    chk_ready("stats0_ready", 8'h1F);
    tick();
    req_valid = 8'hE0;
    #1;
    chk_ready("stats1_ready", 8'hE0);
    tick();
    req_valid = '0;
    for (int k = 0; k < 3; k++)
      chk_lane("stats1_bus", k, 1'b1, RW'(k + 15), 32'hA000_0000 + 32'(k + 5));
    chk_lane("stats1_bus", 3, 1'b0, '0, '0);
    chk_cnt("stats_cnt", 6, 32);

    // Reset while lanes are carrying data: everything drops immediately.
    set_all();
    tick();
    chk_lane("pre_rst", 0, 1'b1, 5'd10, 32'hA000_0000);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("mid_rst_bus");
    chk_ready("mid_rst_ready", '0);
    chk_cnt("mid_rst_cnt", 0, 0);
    rst = 1'b1;
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 8, number of functional-unit result requesters.
REQ-002 Parameter: NUM_LANES, 5, number of common-data-bus lanes driven into the ROB and reservation stations.
REQ-003 Parameter: ROB_IDX_W, 5, ROB index width (32-entry ROB).
REQ-004 Parameter: DATA_W, 32, result value width.
REQ-005 Port: clk  input  1  single clock, rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-low reset.
REQ-007 Port: req_valid  input  NUM_REQ  per-requester result-valid.
REQ-008 Port: req_rob  input  NUM_REQ x ROB_IDX_W  destination ROB index per requester.
REQ-009 Port: req_value  input  NUM_REQ x DATA_W  result value per requester.
REQ-010 Port: req_ready  output  NUM_REQ  per-requester grant; the transfer occurs on valid&ready.
REQ-011 Port: flush  input  1  squash all in-flight requests and reset fairness state.
REQ-012 Port: bus  output  NUM_LANES x rv_structs::data_bus  registered CDB lanes (valid, dest_rob, value).
REQ-013 Port: stall_count  output  32  cycles in which at least one requester was valid and not ready.
REQ-014 Port: grant_count  output  32  total granted transfers.

Function
REQ-015 Each cycle, the arbiter SHALL scan requesters starting at rr_ptr, ascending modulo NUM_REQ, and grant the first min(NUM_LANES, valid count) valid requesters.
REQ-016 req_ready SHALL be combinational in the same cycle; it SHALL be 1 only for granted requesters and SHALL never be 1 for a requester whose req_valid is 0.
REQ-017 The k-th granted requester in scan order SHALL be registered onto bus[k] at the next rising edge; latency is exactly 1 cycle.
REQ-018 Ungranted lanes SHALL have valid=0, dest_rob=0 and value=0 on the next cycle.
REQ-019 The rr_ptr SHALL update to (index of last granted requester + 1) mod NUM_REQ, and SHALL be held when nothing is granted.
REQ-020 A requester SHALL hold req_valid, req_rob and req_value stable until it is granted; the arbiter SHALL NOT depend on data changing while req_valid=1.
REQ-021 Any valid requester SHALL be granted within ceil(NUM_REQ/NUM_LANES) cycles (2 at the defaults), so no requester starves.
REQ-022 When flush=1, all req_ready SHALL be 0, every bus lane SHALL have valid=0 on the next cycle, and rr_ptr SHALL become 0.
REQ-023 Duplicate req_rob values among granted requesters are forwarded unchanged; the ROB owns uniqueness.
REQ-024 There SHALL be no combinational path from bus to req_ready.

Reset
REQ-025 While rst=0, the block SHALL asynchronously force all bus fields to 0, rr_ptr to 0, stall_count to 0 and grant_count to 0.
REQ-026 req_ready SHALL be 0 while rst=0; arbitration resumes on the first rising edge after rst is deasserted.
REQ-027 A reset asserted mid-transfer SHALL drop the in-flight lanes with no partial output.

Configuration
REQ-028 Macro CDB_ARB_STATS_EN: when defined, stall_count and grant_count SHALL be live saturating 32-bit counters that freeze at 0xFFFFFFFF.
REQ-029 Without CDB_ARB_STATS_EN, stall_count and grant_count SHALL be tied to 0 with no counter flops; the port list is unchanged.

Structure
REQ-030 The default lane count NUM_CDB_LANES=5 and ROB_IDX_W SHALL reside in the shared rv_structs package, alongside data_bus.
REQ-031 Rotating first-N selection SHALL be a sub-module, rr_priority_select (inputs: valid vector and pointer; outputs: grant vector and per-lane requester index).

Verification
REQ-032 Reset: rst=0 with all req_valid=1 -> req_ready=0, all bus.valid=0, counters=0; after release, the first grant is requesters 0-4.
REQ-033 Sparse requests: requesters 1, 4 and 6 valid with rob 3/7/9 and values 0x10/0x20/0x30 -> ready 1, 4 and 6 the same cycle; next cycle bus[0..2] = (3,0x10), (7,0x20), (9,0x30); bus[3..4].valid=0.
REQ-034 Rotation: all 8 valid, rr_ptr=0 -> grants 0-4 and rr_ptr=5; next cycle grants 5, 6, 7, 0, 1 and rr_ptr=2.
REQ-035 Fairness: requester 7 held valid with all others continuously re-asserting -> requester 7 is granted within 2 cycles.
REQ-036 Flush: 6 valid requesters with flush=1 -> all req_ready=0, all bus.valid=0 next cycle, rr_ptr=0.
REQ-037 Stats (CDB_ARB_STATS_EN): 8 valid for one cycle, then requesters 5-7 granted the next cycle -> stall_count=1, grant_count=8.
